// File: rtl/seg7_pkg.sv
// Shared constants, enums and small helpers for the 3-digit 7-segment scan driver.
package seg7_pkg;

   // Active-low segment patterns.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   // Digit being scanned. The value matches the anode bit that digit owns.
   typedef enum logic [1:0] {
      DIG_ONES  = 2'd0,
      DIG_TENS  = 2'd1,
      DIG_HUNDS = 2'd2
   } dig_e;

   // Per-digit scan phase: dark guard interval, then lit dwell interval.
   typedef enum logic {
      DARK = 1'b0,
      ON   = 1'b1
   } scan_e;

   // Active-low anode enable for one digit.
   function automatic logic [2:0] anode_sel(input dig_e d);
      case (d)
         DIG_ONES:  return 3'b110;
         DIG_TENS:  return 3'b101;
         DIG_HUNDS: return 3'b011;
         default:   return 3'b111;
      endcase
   endfunction

   // Scan order is ones -> tens -> hundreds -> ones.
   function automatic dig_e next_digit(input dig_e d);
      case (d)
         DIG_ONES: return DIG_TENS;
         DIG_TENS: return DIG_HUNDS;
         default:  return DIG_ONES;
      endcase
   endfunction

endpackage

// File: rtl/seg7_frame_buf.sv
// Shadow/active double buffer for the three digit patterns. New patterns land
// in the shadow on upd and move to the active set only at a frame boundary.
module seg7_frame_buf
   import seg7_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_hundreds,
   input  logic [6:0] seg_tens,
   input  logic [6:0] seg_ones,
   input  logic       upd,
   input  logic       commit,
   output logic [6:0] act_h,
   output logic [6:0] act_t,
   output logic [6:0] act_o,
   output logic       pending
);

   logic [6:0] shd_h;
   logic [6:0] shd_t;
   logic [6:0] shd_o;

   // Capture into the shadow, then commit (or bypass) into the active set on the frame wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: these are a handful of flops, not a RAM, so every one of them
         // is reset; that also guarantees a pending update dies with the reset.
         shd_h   <= SEG_BLANK;
         shd_t   <= SEG_BLANK;
         shd_o   <= SEG_BLANK;
         act_h   <= SEG_BLANK;
         act_t   <= SEG_BLANK;
         act_o   <= SEG_BLANK;
         pending <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so the active set below
         // takes the shadow's pre-edge value when commit and upd do not overlap.
         if (upd) begin
            shd_h <= seg_hundreds;
            shd_t <= seg_tens;
            shd_o <= seg_ones;
         end
         if (commit) begin
            if (upd) begin
               // Update arriving exactly on the wrap goes straight to the display.
               act_h <= seg_hundreds;
               act_t <= seg_tens;
               act_o <= seg_ones;
            end else if (pending) begin
               act_h <= shd_h;
               act_t <= shd_t;
               act_o <= shd_o;
            end
            pending <= 1'b0;
         end else if (upd) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 3-digit common-anode 7-segment driver with a dark guard
// interval between digits, frame-synchronous pattern updates and optional
// leading-zero blanking. All outputs are registered alongside the scan state.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int DWELL = 50000,
   parameter int GUARD = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_hundreds,
   input  logic [6:0] seg_tens,
   input  logic [6:0] seg_ones,
   input  logic       upd,
   input  logic       blank_lz,
   output logic [6:0] seg_out,
   output logic [2:0] an,
   output logic       frame_tick
);

   localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

   scan_e         state_q, state_d;
   dig_e          idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   logic [6:0]    act_h, act_t, act_o;
   logic          pending;
   logic          blank_h, blank_t;
   logic [6:0]    seg_d;
   logic [2:0]    an_d;

   seg7_frame_buf u_buf (
      .clk          (clk),
      .rst          (rst),
      .seg_hundreds (seg_hundreds),
      .seg_tens     (seg_tens),
      .seg_ones     (seg_ones),
      .upd          (upd),
      .commit       (wrap),
      .act_h        (act_h),
      .act_t        (act_t),
      .act_o        (act_o),
      .pending      (pending)
   );

   // Leading-zero suppression on the active set; blank_lz is used as-is, never buffered.
   assign blank_h = blank_lz && (act_h == SEG_ZERO);
   assign blank_t = blank_h && (act_t == SEG_ZERO);

   // Next scan state/index/count, plus the output values for the cycle being entered.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CW'(1);
      wrap    = 1'b0;
      seg_d   = SEG_BLANK;
      an_d    = 3'b111;

      case (state_q)
         DARK: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = ON;
               cnt_d   = '0;
            end
         end
         ON: begin
            if (cnt_q == DWELL_LAST) begin
               state_d = DARK;
               idx_d   = next_digit(idx_q);
               cnt_d   = '0;
               wrap    = (idx_q == DIG_HUNDS);
            end
         end
         default: begin
            state_d = DARK;
            cnt_d   = '0;
         end
      endcase

      // Outputs are derived from the next state so they switch on the same edge.
      if (state_d == ON) begin
         case (idx_d)
            DIG_ONES: begin
               seg_d = act_o;
               an_d  = anode_sel(DIG_ONES);
            end
            DIG_TENS: begin
               if (!blank_t) begin
                  seg_d = act_t;
                  an_d  = anode_sel(DIG_TENS);
               end
            end
            DIG_HUNDS: begin
               if (!blank_h) begin
                  seg_d = act_h;
                  an_d  = anode_sel(DIG_HUNDS);
               end
            end
            default: begin
               seg_d = SEG_BLANK;
               an_d  = 3'b111;
            end
         endcase
      end
   end

   // Scan state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DARK;
         idx_q      <= DIG_ONES;
         cnt_q      <= '0;
         seg_out    <= SEG_BLANK;
         an         <= 3'b111;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         seg_out    <= seg_d;
         an         <= an_d;
         frame_tick <= wrap;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (DWELL=4, GUARD=2, 18-cycle frame).
// The reference model tracks cycles since reset and derives the expected
// slot from frame-position arithmetic.
module tb_seg7_scan_mux;

   localparam int DWELL = 4;
   localparam int GUARD = 2;
   localparam int SLOT  = DWELL + GUARD;
   localparam int FRAME = 3 * SLOT;

   localparam logic [6:0] BLANK = 7'h7F;
   localparam logic [6:0] ZERO  = 7'b1000000;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_hundreds, seg_tens, seg_ones;
   logic       upd;
   logic       blank_lz;
   logic [6:0] seg_out;
   logic [2:0] an;
   logic       frame_tick;

   seg7_scan_mux #(.DWELL(DWELL), .GUARD(GUARD)) dut (
      .clk          (clk),
      .rst          (rst),
      .seg_hundreds (seg_hundreds),
      .seg_tens     (seg_tens),
      .seg_ones     (seg_ones),
      .upd          (upd),
      .blank_lz     (blank_lz),
      .seg_out      (seg_out),
      .an           (an),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: cycles since reset, shadow/active patterns [0]=ones,[1]=tens,[2]=hundreds.
   int         m_c;
   logic [6:0] m_sh [3];
   logic [6:0] m_act[3];
   logic       m_pend;
   logic [6:0] e_seg;
   logic [2:0] e_an;
   logic       e_tick;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at model cycle %0d: got %0h, expected %0h", tag, m_c, got, exp);
      end
   endtask

   // Apply one clock edge to the model using the inputs being sampled, then compute expectations.
   task automatic model_edge();
      logic [6:0] in[3];
      int pos, slot, w;
      logic bh, bt;
      in[0] = seg_ones; in[1] = seg_tens; in[2] = seg_hundreds;
      if (rst) begin
         m_c = 0;
         m_pend = 1'b0;
         for (int i = 0; i < 3; i++) begin m_sh[i] = BLANK; m_act[i] = BLANK; end
      end else begin
         if (m_c % FRAME == FRAME - 1) begin
            if (upd) begin
               for (int i = 0; i < 3; i++) begin m_sh[i] = in[i]; m_act[i] = in[i]; end
            end else if (m_pend) begin
               for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
            end
            m_pend = 1'b0;
         end else if (upd) begin
            for (int i = 0; i < 3; i++) m_sh[i] = in[i];
            m_pend = 1'b1;
         end
         m_c++;
      end
      pos  = m_c % FRAME;
      slot = pos / SLOT;
      w    = pos % SLOT;
      e_tick = (pos == 0) && (m_c != 0);
      bh = !rst && blank_lz && (m_act[2] == ZERO);
      bt = bh && (m_act[1] == ZERO);
      e_seg = BLANK;
      e_an  = 3'b111;
      if (w >= GUARD && !((slot == 2 && bh) || (slot == 1 && bt))) begin
         e_seg = m_act[slot];
         e_an  = ~(3'b001 << slot);
      end
   endtask

   // One cycle: edge, model update, then sample outputs away from the edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, ".an"}, 32'(an), 32'(e_an));
      check({tag, ".seg"}, 32'(seg_out), 32'(e_seg));
      check({tag, ".tick"}, 32'(frame_tick), 32'(e_tick));
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   // Step until the next edge the model will process sits at the given frame position.
   task automatic run_to_pos(input string tag, input int p);
      for (int i = 0; i < FRAME && (m_c % FRAME) != p; i++) step(tag);
   endtask

   task automatic load(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
      seg_hundreds = h; seg_tens = t; seg_ones = o; upd = 1'b1;
   endtask

   initial begin
      rst = 1'b1; upd = 1'b0; blank_lz = 1'b0;
      seg_hundreds = BLANK; seg_tens = BLANK; seg_ones = BLANK;
      m_c = 0;
      run("reset", 3);
      rst = 1'b0;

      // Reset release: dark/blank scan, first frame_tick at cycle 18.
      run("release", 2 * FRAME);

      // Update mid-frame: nothing visible until the next frame boundary.
      run_to_pos("mid", 7);
      load(7'b1111001, 7'b0100100, 7'b0110000);
      step("mid_upd");
      upd = 1'b0;
      run("mid_show", 2 * FRAME);

      // Update exactly on the wrap edge: shown in the same frame, nothing left pending.
      run_to_pos("wrap", FRAME - 1);
      load(7'b0010010, 7'b0000010, 7'b1111000);
      step("wrap_upd");
      upd = 1'b0;
      check("wrap_pending", 32'(dut.u_buf.pending), 32'(0));
      run("wrap_show", FRAME);

      // Leading-zero blanking: hundreds and tens zero, then only hundreds zero.
      blank_lz = 1'b1;
      load(ZERO, ZERO, 7'b1111001);
      step("lz_upd");
      upd = 1'b0;
      run("lz_ht", 2 * FRAME);
      load(ZERO, 7'b1111001, ZERO);
      step("lz_upd2");
      upd = 1'b0;
      run("lz_h", 2 * FRAME);
      load(ZERO, ZERO, ZERO);
      step("lz_upd3");
      upd = 1'b0;
      run("lz_all0", 2 * FRAME);
      blank_lz = 1'b0;
      run("nolz", FRAME);

      // Reset during the tens ON slot with an update pending.
      load(7'b0011001, 7'b0010010, 7'b0000010);
      step("rst_upd");
      upd = 1'b0;
      run_to_pos("rst_wait", SLOT + GUARD + 1);
      rst = 1'b1;
      step("rst_mid");
      rst = 1'b0;
      run("rst_after", 2 * FRAME);

      // Randomized traffic: updates, blanking toggles, occasional reset.
      for (int i = 0; i < 1500; i++) begin
         upd = ($urandom_range(7) == 0);
         seg_hundreds = ($urandom_range(2) == 0) ? ZERO : 7'($urandom);
         seg_tens     = ($urandom_range(2) == 0) ? ZERO : 7'($urandom);
         seg_ones     = ($urandom_range(3) == 0) ? ZERO : 7'($urandom);
         if ($urandom_range(40) == 0) blank_lz = ~blank_lz;
         rst = ($urandom_range(250) == 0);
         step("rand");
      end
      rst = 1'b0; upd = 1'b0;
      run("tail", FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
